// File: rtl/sprite_obj_stager_pkg.sv
// sprite_obj_stager_pkg
// Shared constants and helpers for the sprite object stager: register
// addresses, CTRL/STATUS bit positions, object geometry and the host
// access-size encoding.
package sprite_obj_stager_pkg;

  localparam int ADDR_W          = 6;
  localparam int DATA_W          = 32;
  localparam int OBJ_BYTES       = 4;
  localparam int NUM_SPRITES_DEF = 4;

  localparam logic [ADDR_W-1:0] ADDR_CTRL      = 6'h20;
  localparam logic [ADDR_W-1:0] ADDR_STATUS    = 6'h21;
  localparam logic [ADDR_W-1:0] ADDR_FRAME_CNT = 6'h22;

  localparam int CTRL_COMMIT_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT     = 1;
  localparam int STATUS_IRQ_PEND_BIT = 0;

  // Active-low access size strobes: 11 idle, 00 byte, 01 half, 10 word.
  typedef enum logic [1:0] {
    ACC_BYTE = 2'b00,
    ACC_HALF = 2'b01,
    ACC_WORD = 2'b10,
    ACC_NONE = 2'b11
  } acc_e;

  // Byte lanes touched by an access. Misaligned half/word accesses
  // produce an empty mask so they are dropped as a whole.
  function automatic logic [3:0] lane_mask(input logic [1:0] acc,
                                           input logic [ADDR_W-1:0] addr);
    case (acc)
      ACC_BYTE: lane_mask = 4'b0001;
      ACC_HALF: lane_mask = addr[0] ? 4'b0000 : 4'b0011;
      ACC_WORD: lane_mask = (addr[1:0] != 2'b00) ? 4'b0000 : 4'b1111;
      default:  lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/sprite_obj_stager_if.sv
// sprite_obj_stager_if
// Host bus of the stager.
//   address      byte address within the peripheral window
//   data_in      write data, little-endian lanes
//   data_write_n write size strobe (acc_e encoding)
//   data_read_n  read size strobe (acc_e encoding)
//   data_out     read data
//   data_ready   acknowledge
interface sprite_obj_stager_if;
  import sprite_obj_stager_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [1:0]        data_write_n;
  logic [1:0]        data_read_n;
  logic [DATA_W-1:0] data_out;
  logic              data_ready;

  modport master (
    output address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready
  );

  modport slave (
    input  address, data_in, data_write_n, data_read_n,
    output data_out, data_ready
  );
endinterface

// File: rtl/sprite_obj_stager_vsync_edge_det.sv
// vsync_edge_det
// Registers vsync once and produces a rising-edge pulse (vsync & ~vsync_q).
// The pulse is only armed after vsync has been seen low since reset, so a
// reset released while vsync is high does not fake an edge.
//   clk, reset  clock, async active-high reset
//   vsync       raw vsync level
//   vsync_rise  high in the cycle vsync first reads 1 after reading 0
module vsync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic vsync_rise
);

  logic vsync_q, vsync_d;
  logic armed_q, armed_d;

  always_comb begin
    vsync_d = vsync;
    armed_d = armed_q | ~vsync;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      vsync_q <= vsync_d;
      armed_q <= armed_d;
    end
  end

  assign vsync_rise = vsync & ~vsync_q & armed_q;

endmodule

// File: rtl/sprite_obj_stager.sv
// sprite_obj_stager
// Double-buffered sprite attribute store. The host fills a staging bank
// over the bus and requests a commit; on the next vsync rising edge the
// staging bank is copied into the active bank read by the renderer. Each
// edge also bumps FRAME_CNT and, when enabled, raises a vblank interrupt.
//   clk, reset      clock, async active-high reset
//   bus             host register bus (slave side)
//   vsync           video timing vsync
//   spr_sel         renderer sprite index
//   spr_attr        {size, bitmap_offset, y, x} of the selected active sprite
//   user_interrupt  vblank interrupt request (IRQ_PEND)
module sprite_obj_stager
  import sprite_obj_stager_pkg::*;
#(
  parameter int NUM_SPRITES = NUM_SPRITES_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  sprite_obj_stager_if.slave        bus,
  input  logic                      vsync,
  input  logic [1:0]                spr_sel,
  output logic [DATA_W-1:0]         spr_attr,
  output logic                      user_interrupt
);

  localparam int NUM_BYTES = NUM_SPRITES * OBJ_BYTES;

  logic [7:0]        staging_q [NUM_BYTES];
  logic [7:0]        staging_d [NUM_BYTES];
  logic [7:0]        active_q  [NUM_BYTES];
  logic [7:0]        active_d  [NUM_BYTES];
  logic [1:0]        ctrl_q, ctrl_d;
  logic              irq_pend_q, irq_pend_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;

  logic              vsync_rise;
  logic [3:0]        wr_lanes, rd_lanes;
  logic [ADDR_W-1:0] lane_addr [4];

  vsync_edge_det u_vsync_edge_det (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .vsync_rise (vsync_rise)
  );

  always_comb begin
    wr_lanes = lane_mask(bus.data_write_n, bus.address);
    rd_lanes = lane_mask(bus.data_read_n, bus.address);
    for (int k = 0; k < 4; k++) begin
      lane_addr[k] = bus.address + ADDR_W'(k);
    end
  end

  function automatic logic [7:0] reg_byte(input logic [ADDR_W-1:0] a);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (a == ADDR_W'(i)) b = staging_q[i];
    end
    if (a == ADDR_CTRL)      b = {6'b0, ctrl_q};
    if (a == ADDR_STATUS)    b = {7'b0, irq_pend_q};
    if (a == ADDR_FRAME_CNT) b = frame_cnt_q;
    return b;
  endfunction

  // Edge actions use the pre-write register values; the host write is then
  // layered on top so the host's value is what survives the cycle.
  always_comb begin
    staging_d   = staging_q;
    active_d    = active_q;
    ctrl_d      = ctrl_q;
    irq_pend_d  = irq_pend_q;
    frame_cnt_d = frame_cnt_q;

    if (vsync_rise) begin
      if (ctrl_q[CTRL_COMMIT_BIT]) begin
        active_d                = staging_q;
        ctrl_d[CTRL_COMMIT_BIT] = 1'b0;
      end
      frame_cnt_d = frame_cnt_q + 8'd1;
    end

    for (int k = 0; k < 4; k++) begin
      if (wr_lanes[k]) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
          if (lane_addr[k] == ADDR_W'(i)) staging_d[i] = bus.data_in[8*k +: 8];
        end
        if (lane_addr[k] == ADDR_CTRL) ctrl_d = bus.data_in[8*k +: 2];
        if (lane_addr[k] == ADDR_STATUS && bus.data_in[8*k + STATUS_IRQ_PEND_BIT])
          irq_pend_d = 1'b0;
      end
    end

    // A vblank set outranks a simultaneous W1C clear.
    if (vsync_rise && ctrl_q[CTRL_IRQ_EN_BIT]) irq_pend_d = 1'b1;
  end

  always_comb begin
    bus.data_out = '0;
    for (int k = 0; k < 4; k++) begin
      if (rd_lanes[k]) bus.data_out[8*k +: 8] = reg_byte(lane_addr[k]);
    end
  end

  always_comb begin
    spr_attr = '0;
    for (int s = 0; s < NUM_SPRITES; s++) begin
      if (spr_sel == 2'(s))
        spr_attr = {active_q[4*s+3], active_q[4*s+2], active_q[4*s+1], active_q[4*s]};
    end
  end

  assign bus.data_ready  = 1'b1;
  assign user_interrupt  = irq_pend_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        staging_q[i] <= 8'h00;
        active_q[i]  <= 8'h00;
      end
      ctrl_q      <= 2'b00;
      irq_pend_q  <= 1'b0;
      frame_cnt_q <= 8'h00;
    end else begin
      staging_q   <= staging_d;
      active_q    <= active_d;
      ctrl_q      <= ctrl_d;
      irq_pend_q  <= irq_pend_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_sprite_obj_stager.sv
module tb_sprite_obj_stager;
  import sprite_obj_stager_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        vsync = 1'b0;
  logic [1:0]  spr_sel = 2'd0;
  logic [31:0] spr_attr;
  logic        user_interrupt;

  sprite_obj_stager_if bus ();

  sprite_obj_stager #(.NUM_SPRITES(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus.slave),
    .vsync          (vsync),
    .spr_sel        (spr_sel),
    .spr_attr       (spr_attr),
    .user_interrupt (user_interrupt)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: byte arrays and flags updated by the register rules.
  logic [7:0] m_stage [16];
  logic [7:0] m_active [16];
  logic       m_commit, m_irq_en, m_irq;
  logic [7:0] m_frame;
  logic       m_prev_vs, m_seen_low;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_stage[i] = 8'h00;
      m_active[i] = 8'h00;
    end
    m_commit = 0; m_irq_en = 0; m_irq = 0; m_frame = 8'h00;
    m_prev_vs = 0; m_seen_low = 0;
  endtask

  function automatic int acc_len(input logic [1:0] m, input logic [5:0] a);
    if (m == 2'b00) return 1;
    if (m == 2'b01) return (a % 2 == 0) ? 2 : 0;
    if (m == 2'b10) return (a % 4 == 0) ? 4 : 0;
    return 0;
  endfunction

  function automatic logic [7:0] m_byte(input logic [5:0] a);
    if (a < 16) return m_stage[a];
    if (a == 6'h20) return {6'b0, m_irq_en, m_commit};
    if (a == 6'h21) return {7'b0, m_irq};
    if (a == 6'h22) return m_frame;
    return 8'h00;
  endfunction

  function automatic logic [31:0] m_read(input logic [5:0] a, input logic [1:0] m);
    logic [31:0] r;
    logic [5:0]  ak;
    r = 0;
    for (int k = 0; k < acc_len(m, a); k++) begin
      ak = a + 6'(k);
      r[8*k +: 8] = m_byte(ak);
    end
    return r;
  endfunction

  function automatic logic [31:0] m_attr(input logic [1:0] s);
    int b;
    b = 4 * int'(s);
    return {m_active[b+3], m_active[b+2], m_active[b+1], m_active[b]};
  endfunction

  // One clock edge of the model, using the inputs presented at that edge.
  task automatic m_posedge();
    logic rise, pre_commit, pre_irq_en, clr;
    logic [5:0] ak;
    logic [7:0] d;
    rise = vsync && !m_prev_vs && m_seen_low;
    pre_commit = m_commit;
    pre_irq_en = m_irq_en;
    clr = 0;
    if (rise) begin
      if (pre_commit) begin
        for (int i = 0; i < 16; i++) m_active[i] = m_stage[i];
        m_commit = 0;
      end
      m_frame = m_frame + 8'd1;
    end
    for (int k = 0; k < acc_len(bus.data_write_n, bus.address); k++) begin
      ak = bus.address + 6'(k);
      d = bus.data_in[8*k +: 8];
      if (ak < 16) m_stage[ak] = d;
      if (ak == 6'h20) begin
        m_commit = d[0];
        m_irq_en = d[1];
      end
      if (ak == 6'h21 && d[0]) clr = 1;
    end
    if (clr) m_irq = 0;
    if (rise && pre_irq_en) m_irq = 1;
    if (!vsync) m_seen_low = 1;
    m_prev_vs = vsync;
  endtask

  task automatic tick();
    @(posedge clk);
    m_posedge();
    #1;
    chk("irq", {31'b0, user_interrupt}, {31'b0, m_irq});
    chk("attr", spr_attr, m_attr(spr_sel));
    chk("ready", {31'b0, bus.data_ready}, 32'd1);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] m);
    bus.address = a;
    bus.data_in = d;
    bus.data_write_n = m;
    tick();
    bus.data_write_n = 2'b11;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a, input logic [1:0] m);
    bus.address = a;
    bus.data_read_n = m;
    #1;
    chk(tag, bus.data_out, m_read(a, m));
    bus.data_read_n = 2'b11;
  endtask

  task automatic rd_lit(input string tag, input logic [5:0] a, input logic [1:0] m,
                        input logic [31:0] exp);
    bus.address = a;
    bus.data_read_n = m;
    #1;
    chk(tag, bus.data_out, exp);
    bus.data_read_n = 2'b11;
  endtask

  task automatic pulse();
    vsync = 1; tick(); tick();
    vsync = 0; tick();
  endtask

  initial begin
    logic [7:0]  f0;
    logic [31:0] w0;
    logic [5:0]  a;
    logic [1:0]  m;

    bus.address = 0; bus.data_in = 0;
    bus.data_write_n = 2'b11; bus.data_read_n = 2'b11;
    m_reset();

    // Reset state
    #1 reset = 1;
    #2;
    chk("rst_irq", {31'b0, user_interrupt}, 32'd0);
    chk("rst_attr", spr_attr, 32'd0);
    rd_lit("rst_frame", 6'h22, 2'b00, 32'd0);
    rd_lit("idle_out", 6'h22, 2'b11, 32'd0);
    @(negedge clk) reset = 0;
    tick(); tick();

    // Staging write without commit leaves active bank alone
    wr(6'h04, 32'h0F102030, 2'b10);
    pulse();
    spr_sel = 1; #1;
    chk("nocommit_attr", spr_attr, 32'd0);
    rd_lit("stage_word", 6'h04, 2'b10, 32'h0F102030);

    // Commit on next edge
    wr(6'h20, 32'h01, 2'b00);
    pulse();
    chk("commit_attr", spr_attr, 32'h0F102030);
    rd_lit("commit_cleared", 6'h20, 2'b00, 32'h00);
    rd_chk("frame_after2", 6'h22, 2'b00);

    // Vblank interrupt and W1C
    wr(6'h20, 32'h02, 2'b00);
    vsync = 1; tick(); tick();
    chk("irq_set", {31'b0, user_interrupt}, 32'd1);
    vsync = 0; tick();
    wr(6'h21, 32'h01, 2'b00);
    chk("irq_cleared", {31'b0, user_interrupt}, 32'd0);

    // W1C in the edge cycle: set wins
    vsync = 1;
    wr(6'h21, 32'h01, 2'b00);
    chk("set_wins", {31'b0, user_interrupt}, 32'd1);
    vsync = 0; tick();

    // Staging write in the edge cycle: active gets old staging
    wr(6'h00, 32'h55, 2'b00);
    wr(6'h20, 32'h03, 2'b00);
    vsync = 1;
    wr(6'h00, 32'hAA, 2'b00);
    vsync = 0; tick();
    spr_sel = 0; #1;
    chk("edge_stage_x", {24'b0, spr_attr[7:0]}, 32'h55);
    rd_lit("stage_new", 6'h00, 2'b00, 32'hAA);
    rd_lit("ctrl_after", 6'h20, 2'b00, 32'h02);

    // CTRL write in the edge cycle: pre-write commit used, host value kept
    wr(6'h20, 32'h03, 2'b00);
    tick();
    vsync = 1;
    wr(6'h20, 32'h03, 2'b00);
    vsync = 0; tick();
    chk("ctrl_edge_x", {24'b0, spr_attr[7:0]}, 32'hAA);
    rd_lit("ctrl_kept", 6'h20, 2'b00, 32'h03);

    // Misaligned writes dropped
    w0 = m_read(6'h00, 2'b10);
    wr(6'h02, 32'hDEADBEEF, 2'b10);
    wr(6'h01, 32'h0000C0DE, 2'b01);
    rd_lit("misalign_word0", 6'h00, 2'b10, w0);
    rd_chk("misalign_ctrl", 6'h20, 2'b10);

    // FRAME_CNT is read-only and wraps after 256 edges
    wr(6'h22, 32'h77, 2'b00);
    rd_chk("frame_ro", 6'h22, 2'b00);
    f0 = m_frame;
    for (int i = 0; i < 256; i++) pulse();
    rd_lit("frame_wrap", 6'h22, 2'b00, {24'b0, f0});

    // Randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      spr_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) vsync = ~vsync;
      if ($urandom_range(0, 9) < 5) begin
        case ($urandom_range(0, 2))
          0: a = 6'($urandom_range(0, 15));
          1: a = 6'($urandom_range(6'h1E, 6'h23));
          default: a = 6'($urandom_range(0, 63));
        endcase
        m = 2'($urandom_range(0, 2));
        wr(a, $urandom, m);
      end else begin
        tick();
      end
      m = 2'($urandom_range(0, 2));
      a = 6'($urandom_range(0, 63));
      if (m == 2'b01) a[0] = 1'b0;
      if (m == 2'b10) a[1:0] = 2'b00;
      rd_chk("rand_rd", a, m);
    end

    // Async reset mid-frame with interrupt pending and live active bank
    vsync = 0; tick();
    wr(6'h00, 32'h11223344, 2'b10);
    wr(6'h20, 32'h03, 2'b00);
    pulse();
    spr_sel = 0; #1;
    chk("pre_rst_irq", {31'b0, user_interrupt}, 32'd1);
    chk("pre_rst_attr", spr_attr, 32'h11223344);
    #3 reset = 1;
    m_reset();
    #1;
    chk("async_irq", {31'b0, user_interrupt}, 32'd0);
    chk("async_attr", spr_attr, 32'd0);
    rd_lit("async_frame", 6'h22, 2'b00, 32'd0);

    // Reset released with vsync high: no edge until it falls and rises
    vsync = 1;
    @(negedge clk) reset = 0;
    tick(); tick(); tick();
    rd_lit("vs_high_frame", 6'h22, 2'b00, 32'd0);
    vsync = 0; tick();
    vsync = 1; tick(); tick();
    rd_lit("vs_rearm_frame", 6'h22, 2'b00, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
